// File: rtl/pixel_gather.sv
// pixel_gather: collects a raster of RGB pixels arriving one per HSYNC cycle
// and emits them packed LANES-wide. Each beat is flagged with line-end and
// frame-end markers. A VSYNC arriving mid-frame aborts the frame and restarts it.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset; pixels ignored, waiting for first VSYNC
// ACTIVE | frame in progress; pixels accepted and packed into beats
// DONE   | full frame delivered; FRAME_DONE held until next VSYNC

module pixel_gather #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int LANES  = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 VSYNC,
  input  logic                 HSYNC,
  input  logic [7:0]           DATA_R,
  input  logic [7:0]           DATA_G,
  input  logic [7:0]           DATA_B,
  output logic                 OUT_VALID,
  output logic [8*LANES-1:0]   OUT_R,
  output logic [8*LANES-1:0]   OUT_G,
  output logic [8*LANES-1:0]   OUT_B,
  output logic                 OUT_LINE_END,
  output logic                 OUT_FRAME_END,
  output logic                 FRAME_DONE,
  output logic                 ERR_ABORT
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int LW = (LANES  > 1) ? $clog2(LANES)  : 1;

  localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t               state;
  logic [XW-1:0]        x;
  logic [YW-1:0]        y;
  logic [LW-1:0]        lane_cnt;
  logic [8*LANES-1:0]   buf_r;
  logic [8*LANES-1:0]   buf_g;
  logic [8*LANES-1:0]   buf_b;

  logic                 pixel_take;
  logic                 lane_last;
  logic                 x_last;
  logic                 y_last;
  logic [8*LANES-1:0]   pack_r;
  logic [8*LANES-1:0]   pack_g;
  logic [8*LANES-1:0]   pack_b;

  // VSYNC always wins over HSYNC, so a coincident pixel is never accepted.
  assign pixel_take = (state == ACTIVE) && HSYNC && !VSYNC;
  assign lane_last  = (lane_cnt == LANE_LAST);
  assign x_last     = (x == X_LAST);
  assign y_last     = (y == Y_LAST);

  // Merge the incoming pixel into its lane slot so a completed beat can be
  // registered straight to the outputs in the same cycle as its last pixel.
  always_comb begin
    pack_r = buf_r;
    pack_g = buf_g;
    pack_b = buf_b;
    pack_r[{lane_cnt, 3'b000} +: 8] = DATA_R;
    pack_g[{lane_cnt, 3'b000} +: 8] = DATA_G;
    pack_b[{lane_cnt, 3'b000} +: 8] = DATA_B;
  end

  // Frame FSM with counters, lane buffers and registered outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      lane_cnt      <= '0;
      buf_r         <= '0;
      buf_g         <= '0;
      buf_b         <= '0;
      OUT_VALID     <= 1'b0;
      OUT_R         <= '0;
      OUT_G         <= '0;
      OUT_B         <= '0;
      OUT_LINE_END  <= 1'b0;
      OUT_FRAME_END <= 1'b0;
      FRAME_DONE    <= 1'b0;
      ERR_ABORT     <= 1'b0;
    end else begin
      // Pulses default low; beat data holds its last value.
      OUT_VALID     <= 1'b0;
      OUT_LINE_END  <= 1'b0;
      OUT_FRAME_END <= 1'b0;
      ERR_ABORT     <= 1'b0;

      unique case (state)
        IDLE: begin
          if (VSYNC) begin
            state    <= ACTIVE;
            x        <= '0;
            y        <= '0;
            lane_cnt <= '0;
          end
        end

        ACTIVE: begin
          if (VSYNC) begin
            // Restart the frame; any partially filled beat is dropped.
            x         <= '0;
            y         <= '0;
            lane_cnt  <= '0;
            ERR_ABORT <= 1'b1;
          end else if (pixel_take) begin
            buf_r <= pack_r;
            buf_g <= pack_g;
            buf_b <= pack_b;

            if (lane_last) begin
              lane_cnt      <= '0;
              OUT_VALID     <= 1'b1;
              OUT_R         <= pack_r;
              OUT_G         <= pack_g;
              OUT_B         <= pack_b;
              OUT_LINE_END  <= x_last;
              OUT_FRAME_END <= x_last && y_last;
            end else begin
              lane_cnt <= lane_cnt + LW'(1);
            end

            if (x_last) begin
              x <= '0;
              if (y_last) begin
                y          <= '0;
                state      <= DONE;
                FRAME_DONE <= 1'b1;
              end else begin
                y <= y + YW'(1);
              end
            end else begin
              x <= x + XW'(1);
            end
          end
        end

        DONE: begin
          if (VSYNC) begin
            state      <= ACTIVE;
            FRAME_DONE <= 1'b0;
            x          <= '0;
            y          <= '0;
            lane_cnt   <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_gather.sv
// Bench for pixel_gather at WIDTH=8, HEIGHT=2, LANES=4. A reference model
// fed alongside the stimulus pushes expected beats and abort pulses into
// queues; a monitor on the falling edge pops and compares them.

module tb_pixel_gather;
  localparam int W = 8;
  localparam int H = 2;
  localparam int L = 4;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          VSYNC = 1'b0;
  logic          HSYNC = 1'b0;
  logic [7:0]    DATA_R = '0;
  logic [7:0]    DATA_G = '0;
  logic [7:0]    DATA_B = '0;
  logic          OUT_VALID;
  logic [8*L-1:0] OUT_R, OUT_G, OUT_B;
  logic          OUT_LINE_END, OUT_FRAME_END, FRAME_DONE, ERR_ABORT;

  pixel_gather #(.WIDTH(W), .HEIGHT(H), .LANES(L)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .DATA_R(DATA_R), .DATA_G(DATA_G), .DATA_B(DATA_B),
    .OUT_VALID(OUT_VALID), .OUT_R(OUT_R), .OUT_G(OUT_G), .OUT_B(OUT_B),
    .OUT_LINE_END(OUT_LINE_END), .OUT_FRAME_END(OUT_FRAME_END),
    .FRAME_DONE(FRAME_DONE), .ERR_ABORT(ERR_ABORT)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] r, g, b;
    logic        le, fe;
    int          due;
  } beat_t;

  typedef struct {
    int          gap;
    logic [7:0]  base;
    logic [31:0] first_r;
    logic [3:0]  le_mask;
    logic [3:0]  fe_mask;
  } vec_t;

  beat_t exp_q[$];
  int    err_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  // reference model state
  int         m_state = 0;   // 0 idle, 1 active, 2 done
  int         m_lane = 0, m_x = 0, m_y = 0;
  logic       m_done = 1'b0;
  logic [7:0] mr[L], mg[L], mb[L];

  // monitor capture
  int          beats = 0;
  int          errs = 0;
  logic [31:0] beat_r[8];
  logic [3:0]  le_m, fe_m;
  logic [31:0] prev_r = '0, prev_g = '0, prev_b = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus; the model advances at the sampling edge.
  task automatic cycle(input logic vs, input logic hs, input logic [7:0] r);
    int c;
    VSYNC = vs; HSYNC = hs;
    DATA_R = r; DATA_G = r ^ 8'h5A; DATA_B = ~r;
    c = cyc + 1;
    @(posedge HCLK);
    if (vs) begin
      if (m_state == 1) err_q.push_back(c);
      m_state = 1; m_lane = 0; m_x = 0; m_y = 0; m_done = 1'b0;
    end else if (hs && m_state == 1) begin
      mr[m_lane] = r; mg[m_lane] = r ^ 8'h5A; mb[m_lane] = ~r;
      if (m_lane == L - 1) begin
        beat_t bt;
        bt.r = {mr[3], mr[2], mr[1], mr[0]};
        bt.g = {mg[3], mg[2], mg[1], mg[0]};
        bt.b = {mb[3], mb[2], mb[1], mb[0]};
        bt.le = (m_x == W - 1);
        bt.fe = (m_x == W - 1) && (m_y == H - 1);
        bt.due = c;
        exp_q.push_back(bt);
        m_lane = 0;
      end else begin
        m_lane++;
      end
      if (m_x == W - 1) begin
        m_x = 0;
        if (m_y == H - 1) begin
          m_y = 0; m_state = 2; m_done = 1'b1;
        end else begin
          m_y++;
        end
      end else begin
        m_x++;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 8'h00);
  endtask

  // Reset with VSYNC/HSYNC also asserted; reset must win.
  task automatic reset_dut();
    HRESET = 1'b1; VSYNC = 1'b1; HSYNC = 1'b1; DATA_R = 8'h77;
    @(posedge HCLK);
    m_state = 0; m_lane = 0; m_x = 0; m_y = 0; m_done = 1'b0;
    #1;
    @(posedge HCLK); #1;
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_out_r", OUT_R, 0);
    chk("rst_out_g", OUT_G, 0);
    chk("rst_out_b", OUT_B, 0);
    chk("rst_line_end", OUT_LINE_END, 0);
    chk("rst_frame_end", OUT_FRAME_END, 0);
    chk("rst_frame_done", FRAME_DONE, 0);
    chk("rst_err_abort", ERR_ABORT, 0);
    HRESET = 1'b0; VSYNC = 1'b0; HSYNC = 1'b0;
  endtask

  task automatic clear_capture();
    beats = 0; errs = 0; le_m = '0; fe_m = '0;
    for (int i = 0; i < 8; i++) beat_r[i] = '0;
  endtask

  task automatic run_frame(input int gap, input logic [7:0] base);
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, base + 8'(i));
      idle(gap);
    end
    idle(3);
  endtask

  // Monitor: scoreboard pops, hold/zero rules, FRAME_DONE level, aborts.
  always @(negedge HCLK) begin
    if (HRESET) begin
      prev_r = OUT_R; prev_g = OUT_G; prev_b = OUT_B;
    end else begin
      chk("frame_done", FRAME_DONE, m_done);
      if (OUT_VALID) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_beat: got OUT_R %0h with no beat expected (cycle %0d)", OUT_R, cyc);
        end else begin
          beat_t bt;
          bt = exp_q.pop_front();
          chk("beat_r", OUT_R, bt.r);
          chk("beat_g", OUT_G, bt.g);
          chk("beat_b", OUT_B, bt.b);
          chk("beat_line_end", OUT_LINE_END, bt.le);
          chk("beat_frame_end", OUT_FRAME_END, bt.fe);
          chk("beat_latency", cyc, bt.due);
        end
        if (beats < 8) beat_r[beats] = OUT_R;
        if (beats < 4) begin
          le_m[beats] = OUT_LINE_END;
          fe_m[beats] = OUT_FRAME_END;
        end
        beats++;
      end else begin
        chk("idle_line_end", OUT_LINE_END, 0);
        chk("idle_frame_end", OUT_FRAME_END, 0);
        chk("hold_r", OUT_R, prev_r);
        chk("hold_g", OUT_G, prev_g);
        chk("hold_b", OUT_B, prev_b);
      end
      if (ERR_ABORT) begin
        errs++;
        if (err_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_abort: got ERR_ABORT=1 expected 0 (cycle %0d)", cyc);
        end else begin
          chk("abort_latency", cyc, err_q.pop_front());
        end
      end
      prev_r = OUT_R; prev_g = OUT_G; prev_b = OUT_B;
    end
  end

  vec_t tbl[4];

  initial begin
    tbl[0] = '{gap: 0, base: 8'h00, first_r: 32'h03020100, le_mask: 4'b1010, fe_mask: 4'b1000};
    tbl[1] = '{gap: 1, base: 8'h00, first_r: 32'h03020100, le_mask: 4'b1010, fe_mask: 4'b1000};
    tbl[2] = '{gap: 0, base: 8'h40, first_r: 32'h43424140, le_mask: 4'b1010, fe_mask: 4'b1000};
    tbl[3] = '{gap: 3, base: 8'h80, first_r: 32'h83828180, le_mask: 4'b1010, fe_mask: 4'b1000};

    reset_dut();
    idle(2);

    // whole frames: back-to-back, gapped, different data
    for (int i = 0; i < 4; i++) begin
      clear_capture();
      run_frame(tbl[i].gap, tbl[i].base);
      chk("frame_beats", beats, 4);
      chk("frame_first_r", beat_r[0], tbl[i].first_r);
      chk("frame_le_mask", le_m, tbl[i].le_mask);
      chk("frame_fe_mask", fe_m, tbl[i].fe_mask);
      chk("frame_done_level", FRAME_DONE, 1);
      chk("frame_no_abort", errs, 0);
    end

    // HSYNC in DONE is ignored
    clear_capture();
    repeat (4) cycle(1'b0, 1'b1, 8'h99);
    idle(2);
    chk("done_hsync_beats", beats, 0);
    chk("done_hsync_level", FRAME_DONE, 1);

    // mid-frame VSYNC aborts and restarts
    clear_capture();
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'(i));
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h20 + 8'(i));
    idle(3);
    chk("abort_count", errs, 1);
    chk("abort_beats", beats, 5);
    chk("abort_first_r", beat_r[0], 32'h03020100);
    chk("abort_first_le", le_m[0], 0);
    chk("restart_first_r", beat_r[1], 32'h23222120);
    chk("restart_done", FRAME_DONE, 1);

    // HSYNC in IDLE is ignored; VSYNC+HSYNC drops the coincident pixel
    reset_dut();
    clear_capture();
    repeat (4) cycle(1'b0, 1'b1, 8'h99);
    idle(2);
    chk("idle_hsync_beats", beats, 0);
    cycle(1'b1, 1'b1, 8'hAA);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'(i));
    idle(2);
    chk("vs_hs_first_r", beat_r[0], 32'h03020100);
    // same collision while ACTIVE: abort, pixel dropped
    cycle(1'b1, 1'b1, 8'hBB);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h30 + 8'(i));
    idle(3);
    chk("vs_hs_active_abort", errs, 1);
    chk("vs_hs_active_first_r", beat_r[1], 32'h33323130);
    chk("vs_hs_active_beats", beats, 5);

    // reset in the middle of a beat
    clear_capture();
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h50);
    cycle(1'b0, 1'b1, 8'h51);
    reset_dut();
    idle(2);
    chk("reset_partial_beats", beats, 0);
    run_frame(0, 8'h00);
    chk("post_reset_beats", beats, 4);
    chk("post_reset_first_r", beat_r[0], 32'h03020100);
    chk("post_reset_le_mask", le_m, 4'b1010);
    chk("post_reset_fe_mask", fe_m, 4'b1000);

    chk("beats_outstanding", exp_q.size(), 0);
    chk("aborts_outstanding", err_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
